dm_lsu_mem: RTL and testbench

- Parametrised successor to the MIPS32 pipeline's byte-enabled data memory, sitting in the MEM stage.
- Accepts load/store requests with an explicit access size, and generates byte enables and lane steering internally.
- Returns sign- or zero-extended load data one cycle later.
- Flags misaligned and out-of-range accesses.
- Clears its contents after reset with a sequencer FSM instead of a single-cycle wipe.

---
 rtl/dm_lsu_mem_if.sv | 24 ++
 rtl/dm_lsu_mem.sv | 129 ++++++++++++
 tb/tb_dm_lsu_mem.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dm_lsu_mem_if.sv
// Request/response bundle between the MEM stage and the byte-lane data memory.
interface dm_lsu_mem_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err_align;
  logic        err_range;
  logic        busy;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  rdata, rvalid, err_align, err_range, busy
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output rdata, rvalid, err_align, err_range, busy
  );
endinterface

// File: rtl/dm_lsu_mem.sv
// Byte-enabled data memory for the MEM stage: lane steering, load extension,
// misalign/range flags and a post-reset clear sequencer.
module dm_lsu_mem #(
  parameter int unsigned ADDR_W         = 11,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  dm_lsu_mem_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic                clr_we;

  logic [31:0]         mem [DEPTH];

  logic [31:0]         off;
  logic [ADDR_W-1:0]   index;
  logic [1:0]          lane;
  logic                range_bad, align_bad, acc, good;
  logic [3:0]          be;
  logic [31:0]         wrep;
  logic [31:0]         word;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr_we     = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we   = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == '1) state_next = S_IDLE;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state == S_CLEAR);

  // Offset is taken modulo 2^32, so addresses below the base land far out of range.
  assign off       = bus.addr - BASE_ADDR;
  assign index     = off[ADDR_W+1:2];
  assign lane      = off[1:0];
  assign range_bad = (off >> (ADDR_W + 2)) != 32'd0;
  assign align_bad = (bus.size == 2'b11) ||
                     ((bus.size == 2'b01) && off[0]) ||
                     ((bus.size == 2'b10) && (lane != 2'b00));
  assign acc       = bus.req && (state == S_IDLE);
  assign good      = acc && !range_bad && !align_bad;

  always_comb begin
    be   = '0;
    wrep = bus.wdata;
    case (bus.size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << lane;
        wrep = {2{bus.wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (good && bus.we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[index][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  assign word = mem[index];

  always_comb begin
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (bus.size)
      2'b00:   load_val = {{24{bus.sext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{bus.sext & half_v[15]}}, half_v};
      default: load_val = word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rdata     <= '0;
      bus.rvalid    <= 1'b0;
      bus.err_align <= 1'b0;
      bus.err_range <= 1'b0;
    end else begin
      bus.rvalid    <= good && !bus.we;
      bus.err_align <= acc && align_bad;
      bus.err_range <= acc && range_bad;
      if (good && !bus.we) bus.rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_dm_lsu_mem.sv
// Directed and randomized checks of dm_lsu_mem against a byte-array reference model.
module tb_dm_lsu_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_lsu_mem_if bus0 ();
  dm_lsu_mem_if bus1 ();

  dm_lsu_mem #(.ADDR_W(4), .BASE_ADDR(32'h0000_0000), .CLEAR_ON_RESET(1'b1))
    u_dut0 (.clk(clk), .reset(rst), .bus(bus0));
  dm_lsu_mem #(.ADDR_W(4), .BASE_ADDR(32'h0000_1000), .CLEAR_ON_RESET(1'b1))
    u_dut1 (.clk(clk), .reset(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [7:0]  mb     [2][64];
  logic [31:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) mb[d][i] = 8'h00;
      exp_rd[d] = 32'h0;
    end
  endtask

  task automatic check_outputs(input int d, input string tag, input logic [31:0] rd,
                               input logic rv, input logic ea, input logic er, input logic bz);
    if (d == 0) begin
      chk({tag, ".rdata"},  bus0.rdata,     rd);
      chk({tag, ".rvalid"}, bus0.rvalid,    rv);
      chk({tag, ".ealign"}, bus0.err_align, ea);
      chk({tag, ".erange"}, bus0.err_range, er);
      chk({tag, ".busy"},   bus0.busy,      bz);
    end else begin
      chk({tag, ".rdata"},  bus1.rdata,     rd);
      chk({tag, ".rvalid"}, bus1.rvalid,    rv);
      chk({tag, ".ealign"}, bus1.err_align, ea);
      chk({tag, ".erange"}, bus1.err_range, er);
      chk({tag, ".busy"},   bus1.busy,      bz);
    end
  endtask

  // One request in a single cycle; outputs checked one edge later.
  task automatic access(input string tag, input int d, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] base, off, v;
    logic rng, aln, ok;
    int nb;
    base = (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
    off  = a - base;
    rng  = (off >= 32'd64);
    aln  = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off[1:0] != 2'b00);
    ok   = !rng && !aln;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (ok && !w) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(mb[d][off[5:0] + k]) << (8 * k));
      if (sx && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sx && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd[d] = v;
    end
    if (ok && w) begin
      for (int k = 0; k < nb; k++) mb[d][off[5:0] + k] = wd[8*k +: 8];
    end

    @(negedge clk);
    if (d == 0) begin
      bus0.req = 1'b1; bus0.we = w; bus0.size = sz; bus0.sext = sx; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = 1'b1; bus1.we = w; bus1.size = sz; bus1.sext = sx; bus1.addr = a; bus1.wdata = wd;
    end
    @(posedge clk);
    #1;
    check_outputs(d, tag, exp_rd[d], ok && !w, aln, rng, 1'b0);
    bus0.req = 1'b0;
    bus1.req = 1'b0;
  endtask

  // Releases reset and counts busy cycles while hammering both DUTs with requests.
  task automatic clear_seq();
    int c0, c1;
    c0 = 0;
    c1 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      chk("busy_req.rvalid0", bus0.rvalid,    1'b0);
      chk("busy_req.ealign0", bus0.err_align, 1'b0);
      chk("busy_req.erange0", bus0.err_range, 1'b0);
      chk("busy_req.rvalid1", bus1.rvalid,    1'b0);
      chk("busy_req.erange1", bus1.err_range, 1'b0);
      if (bus0.busy) c0++;
      if (bus1.busy) c1++;
      if (!bus0.busy && !bus1.busy) break;
      bus0.req = bus0.busy; bus0.we = 1'b1; bus0.size = 2'b10; bus0.addr = 32'h0; bus0.wdata = 32'hDEAD_BEEF;
      bus1.req = bus1.busy; bus1.we = 1'b0; bus1.size = 2'b11; bus1.addr = 32'h0000_0FFC;
      @(negedge clk);
      #1;
    end
    bus0.req = 1'b0;
    bus1.req = 1'b0;
    chk("busy_cycles0", c0, 32'd16);
    chk("busy_cycles1", c1, 32'd16);
    model_clear();
  endtask

  initial begin
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = 2'b00; bus0.sext = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.size = 2'b00; bus1.sext = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    model_clear();

    #12;
    check_outputs(0, "reset0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_outputs(1, "reset1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear_seq();

    access("ld_last_cleared", 0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    access("ld_word0_unwritten", 0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);

    access("st_w10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB);
    access("lb10", 0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    access("lb11", 0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    access("lb12", 0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    access("lb13", 0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    access("lhu12", 0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    access("lbu13", 0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);

    access("st_w20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    access("st_b21", 0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00F0);
    access("ld_w20a", 0, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
    access("st_h22", 0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_5A5A);
    access("ld_w20b", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    access("lh_mis03", 0, 1'b0, 2'b01, 1'b1, 32'h03, 32'h0);
    access("sw_mis06", 0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFF_FFFF);
    access("ld_w04", 0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    access("size11", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

    access("rng_1040", 1, 1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    access("rng_0FFC", 1, 1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0);
    access("st_103C", 1, 1'b1, 2'b10, 1'b0, 32'h0000_103C, 32'hCAFE_F00D);
    access("ld_103C", 1, 1'b0, 2'b10, 1'b0, 32'h0000_103C, 32'h0);
    access("both_err", 1, 1'b0, 2'b01, 1'b0, 32'h0000_1041, 32'h0);

    for (int i = 0; i < 300; i++) begin
      int d, r;
      logic [1:0] sz;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r == 9) ? 2'b11 : 2'(r % 3);
      a  = ((d == 0) ? 32'h0 : 32'h1000) + $urandom_range(0, 67);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      access("rand", d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("midclear_busy0", bus0.busy, 1'b1);
    end
    rst = 1'b1;
    #1;
    check_outputs(0, "midclear_reset0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear_seq();

    for (int w = 0; w < 16; w++) begin
      access("post_clear0", 0, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
      access("post_clear1", 1, 1'b0, 2'b10, 1'b0, 32'h1000 + 32'(w * 4), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
